// File: rtl/booth_accum_if.sv
// Product-in / result-out bundle between the Booth multiplier, the accumulator and its consumer.
interface booth_accum_if #(
  parameter int WIDTH      = 8,
  parameter int ACC_W      = 2*WIDTH+4,
  parameter int FIFO_DEPTH = 4
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic                 prod_valid;
  logic [2*WIDTH-1:0]   prod_in;
  logic                 clear;
  logic                 acc_ready;
  logic                 acc_valid;
  logic [ACC_W-1:0]     acc_out;
  logic                 acc_ovf;
  logic                 drop;
  logic [LW-1:0]        fifo_level;

  modport master (
    output prod_valid, prod_in, clear, acc_ready,
    input  acc_valid, acc_out, acc_ovf, drop, fifo_level
  );

  modport slave (
    input  prod_valid, prod_in, clear, acc_ready,
    output acc_valid, acc_out, acc_ovf, drop, fifo_level
  );
endinterface

// File: rtl/booth_accum.sv
// Buffers Booth products in a small FIFO and sums N_TERMS of them into a signed
// dot-product result with sticky overflow, presented on a valid/ready port.
module booth_accum #(
  parameter int WIDTH      = 8,
  parameter int N_TERMS    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int ACC_W      = 2*WIDTH+4
) (
  input  logic          clk,
  input  logic          rst_n,
  booth_accum_if.slave  bus
);
  localparam int PW = 2*WIDTH;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = $clog2(N_TERMS) + 1;

  typedef enum logic {ACCUM, OUT} state_e;

  state_e                   state_q, state_d;
  logic [PW-1:0]            mem_q [FIFO_DEPTH];
  logic [AW-1:0]            wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]            level_q, level_d;
  logic signed [ACC_W-1:0]  sum_q, sum_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     sticky_q, sticky_d;
  logic [ACC_W-1:0]         acc_out_q, acc_out_d;
  logic                     ovf_q, ovf_d;
  logic                     valid_q, valid_d;
  logic                     drop_q, drop_d;

  logic                     pop, push;
  logic signed [ACC_W-1:0]  head_ext, sum_new;
  logic                     add_ovf;

  assign head_ext = ACC_W'($signed(mem_q[rptr_q]));
  assign sum_new  = sum_q + head_ext;
  assign add_ovf  = (sum_q[ACC_W-1] == head_ext[ACC_W-1]) &&
                    (sum_new[ACC_W-1] != sum_q[ACC_W-1]);

  // A full FIFO still accepts a product when the head leaves on the same edge.
  assign pop  = (state_q == ACCUM) && (level_q != '0);
  assign push = bus.prod_valid && ((level_q != LW'(FIFO_DEPTH)) || pop);

  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    sticky_d  = sticky_q;
    acc_out_d = acc_out_q;
    ovf_d     = ovf_q;
    valid_d   = valid_q;
    drop_d    = bus.prod_valid && !push;
    level_d   = level_q + LW'(push) - LW'(pop);
    if (push) wptr_d = wptr_q + AW'(1);
    case (state_q)
      ACCUM: begin
        if (pop) begin
          rptr_d = rptr_q + AW'(1);
          if (cnt_q == CW'(N_TERMS-1)) begin
            acc_out_d = sum_new;
            ovf_d     = sticky_q | add_ovf;
            valid_d   = 1'b1;
            sum_d     = '0;
            cnt_d     = '0;
            sticky_d  = 1'b0;
            state_d   = OUT;
          end else begin
            sum_d    = sum_new;
            cnt_d    = cnt_q + CW'(1);
            sticky_d = sticky_q | add_ovf;
          end
        end
      end
      OUT: begin
        if (valid_q && bus.acc_ready) begin
          valid_d = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || bus.clear) begin
      state_q   <= ACCUM;
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
      sticky_q  <= 1'b0;
      acc_out_q <= '0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      level_q   <= level_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      sticky_q  <= sticky_d;
      acc_out_q <= acc_out_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
      drop_q    <= drop_d;
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (rst_n && !bus.clear && push) mem_q[wptr_q] <= bus.prod_in;
  end

  assign bus.acc_valid  = valid_q;
  assign bus.acc_out    = acc_out_q;
  assign bus.acc_ovf    = ovf_q;
  assign bus.drop       = drop_q;
  assign bus.fifo_level = level_q;
endmodule

// File: tb/tb_booth_accum.sv
// Drives a 20-bit and a 17-bit accumulator with identical stimulus and checks
// both every cycle against a queue-based reference model.
module tb_booth_accum;
  localparam int WIDTH = 8;
  localparam int NT    = 4;
  localparam int DEPTH = 4;
  localparam int WA    = 20;
  localparam int WB    = 17;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pv = 1'b0;
  logic [15:0] pin = '0;
  logic        clr = 1'b0;
  logic        rdy = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  booth_accum_if #(.WIDTH(WIDTH), .ACC_W(WA), .FIFO_DEPTH(DEPTH)) if_a ();
  booth_accum_if #(.WIDTH(WIDTH), .ACC_W(WB), .FIFO_DEPTH(DEPTH)) if_b ();

  assign if_a.prod_valid = pv;  assign if_b.prod_valid = pv;
  assign if_a.prod_in    = pin; assign if_b.prod_in    = pin;
  assign if_a.clear      = clr; assign if_b.clear      = clr;
  assign if_a.acc_ready  = rdy; assign if_b.acc_ready  = rdy;

  booth_accum #(.WIDTH(WIDTH), .N_TERMS(NT), .FIFO_DEPTH(DEPTH), .ACC_W(WA))
    u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  booth_accum #(.WIDTH(WIDTH), .N_TERMS(NT), .FIFO_DEPTH(DEPTH), .ACC_W(WB))
    u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

  // reference model: product queue, terms of the group in progress, held result
  int     mq[$];
  int     grp[$];
  bit     m_hold;
  bit     m_drop;
  longint m_res[2];
  bit     m_ovf[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h want %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic longint wrapw(longint v, int w);
    longint m = longint'(1) << w;
    longint r = v % m;
    if (r < 0) r += m;
    if (r >= m/2) r -= m;
    return r;
  endfunction

  task automatic fold_group();
    int ws[2] = '{WA, WB};
    for (int k = 0; k < 2; k++) begin
      longint s = 0;
      longint lo = -(longint'(1) << (ws[k]-1));
      longint hi = (longint'(1) << (ws[k]-1)) - 1;
      bit o = 0;
      foreach (grp[i]) begin
        longint t = s + grp[i];
        if (t > hi || t < lo) o = 1;
        s = wrapw(t, ws[k]);
      end
      m_res[k] = s;
      m_ovf[k] = o;
    end
  endtask

  task automatic model_edge();
    if (!rst_n || clr) begin
      mq.delete(); grp.delete();
      m_hold = 0; m_drop = 0;
      m_res = '{0, 0}; m_ovf = '{0, 0};
    end else begin
      bit pop = !m_hold && (mq.size() > 0);
      bit acc = pv && ((mq.size() < DEPTH) || pop);
      m_drop = pv && !acc;
      if (m_hold && rdy) m_hold = 0;
      if (pop) begin
        grp.push_back(mq.pop_front());
        if (grp.size() == NT) begin
          fold_group();
          grp.delete();
          m_hold = 1;
        end
      end
      if (acc) mq.push_back(int'($signed(pin)));
    end
  endtask

  task automatic check_all();
    logic [31:0] ma = (32'd1 << WA) - 1;
    logic [31:0] mb = (32'd1 << WB) - 1;
    chk("a_valid", 32'(if_a.acc_valid), 32'(m_hold));
    chk("a_out",   32'(if_a.acc_out),   32'(m_res[0]) & ma);
    chk("a_ovf",   32'(if_a.acc_ovf),   32'(m_ovf[0]));
    chk("a_drop",  32'(if_a.drop),      32'(m_drop));
    chk("a_level", 32'(if_a.fifo_level), 32'(mq.size()));
    chk("b_valid", 32'(if_b.acc_valid), 32'(m_hold));
    chk("b_out",   32'(if_b.acc_out),   32'(m_res[1]) & mb);
    chk("b_ovf",   32'(if_b.acc_ovf),   32'(m_ovf[1]));
    chk("b_drop",  32'(if_b.drop),      32'(m_drop));
    chk("b_level", 32'(if_b.fifo_level), 32'(mq.size()));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic push(input logic [15:0] v);
    pv = 1'b1; pin = v; step(); pv = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int k = 0;
    while (!if_a.acc_valid && k < budget) begin step(); k++; end
    if (!if_a.acc_valid) chk("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int got[$];
    logic [15:0] t2[4] = '{16'd6, 16'hFFF6, 16'h4000, 16'hC000};

    // reset with a product pending
    rst_n = 1'b0; pv = 1'b1; pin = 16'h1234;
    step(); step();
    chk("rst_level", 32'(if_a.fifo_level), 32'd0);
    chk("rst_drop",  32'(if_a.drop), 32'd0);
    chk("rst_valid", 32'(if_a.acc_valid), 32'd0);
    pv = 1'b0; rst_n = 1'b1; rdy = 1'b1;
    step();

    // basic sum
    for (int i = 0; i < 4; i++) begin
      push(t2[i]);
      if (i == 3) begin
        step();
        chk("t2_valid", 32'(if_a.acc_valid), 32'd1);
        chk("t2_out",   32'(if_a.acc_out), 32'h000FFFFC);
        chk("t2_ovf",   32'(if_a.acc_ovf), 32'd0);
      end
      repeat (9) step();
    end

    // overflow in the narrow instance, then sticky flag cleared
    for (int i = 0; i < 4; i++) begin push(16'h4000); step(); end
    chk("t3_b_out", 32'(if_b.acc_out), 32'h00010000);
    chk("t3_b_ovf", 32'(if_b.acc_ovf), 32'd1);
    chk("t3_a_ovf", 32'(if_a.acc_ovf), 32'd0);
    repeat (3) step();
    for (int i = 0; i < 4; i++) begin push(16'd1); step(); end
    chk("t3_b_out2", 32'(if_b.acc_out), 32'd4);
    chk("t3_b_ovf2", 32'(if_b.acc_ovf), 32'd0);
    repeat (3) step();

    // back-pressure and drop
    rdy = 1'b0;
    for (int i = 1; i <= 4; i++) begin push(16'(i)); step(); end
    wait_valid(10);
    for (int i = 1; i <= 5; i++) push(16'(10*i));
    chk("t4_level", 32'(if_a.fifo_level), 32'd4);
    chk("t4_drop",  32'(if_a.drop), 32'd1);
    step();
    chk("t4_drop_end", 32'(if_a.drop), 32'd0);
    rdy = 1'b1;
    step();
    chk("t4_consumed", 32'(if_a.acc_valid), 32'd0);
    wait_valid(20);
    chk("t4_out", 32'(if_a.acc_out), 32'd100);
    repeat (3) step();

    // clear mid-sum
    push(16'd100); push(16'd200);
    clr = 1'b1; pv = 1'b1; pin = 16'd999;
    step();
    clr = 1'b0; pv = 1'b0;
    chk("t5_level", 32'(if_a.fifo_level), 32'd0);
    step();
    chk("t5_drop", 32'(if_a.drop), 32'd0);
    for (int i = 1; i <= 4; i++) push(16'(i));
    wait_valid(20);
    chk("t5_out", 32'(if_a.acc_out), 32'd10);
    repeat (3) step();

    // streaming
    for (int i = 1; i <= 12; i++) begin
      if (i <= 8) begin pv = 1'b1; pin = 16'(i); end else pv = 1'b0;
      step();
      if (if_a.acc_valid) got.push_back(int'(if_a.acc_out));
    end
    pv = 1'b0;
    repeat (4) begin step(); if (if_a.acc_valid) got.push_back(int'(if_a.acc_out)); end
    chk("t6_count", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      chk("t6_r0", 32'(got[0]), 32'd10);
      chk("t6_r1", 32'(got[1]), 32'd26);
    end
    chk("t6_level", 32'(if_a.fifo_level), 32'd0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      pv  = ($urandom_range(99) < 60);
      pin = ($urandom_range(3) == 0) ? 16'($urandom_range(15)) : 16'($urandom);
      rdy = ($urandom_range(99) < 45);
      clr = ($urandom_range(199) == 0);
      rst_n = ($urandom_range(499) != 0);
      step();
    end
    clr = 1'b0; rst_n = 1'b1; pv = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/booth_accum.md
# booth_accum

Downstream accumulator for the sequential Booth multiplier. It captures each signed product on the multiplier's one-cycle `done` pulse and buffers it in a small FIFO. It sums N_TERMS consecutive products into a signed dot-product result and presents that result on a valid/ready output port. The multiplier cannot be stalled, so the FIFO absorbs products while the output is back-pressured; products that arrive when the FIFO is full are dropped and flagged.

## Interface
- WIDTH, 8: multiplier operand width; each product is 2*WIDTH bits, signed.
- N_TERMS, 4: number of products per result; must be ≥ 1.
- FIFO_DEPTH, 4: product FIFO entries; must be a power of 2 and ≥ 2.
- ACC_W, 2*WIDTH+4: accumulator and result width; must be ≥ 2*WIDTH.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- prod_valid  in  1  connects to the multiplier `done`; each high cycle delivers one product.
- prod_in  in  2*WIDTH  signed two's-complement product; connects to multiplier `M`.
- clear  in  1  synchronous abort: flush the FIFO and discard the partial sum.
- acc_ready  in  1  consumer ready for the result.
- acc_valid  out  1  result valid.
- acc_out  out  ACC_W  signed dot-product result.
- acc_ovf  out  1  signed overflow occurred while forming acc_out; meaningful only while acc_valid is high.
- drop  out  1  one-cycle pulse: a product was rejected because the FIFO was full.
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Reset (rst_n low at an edge):
  - acc_valid=0, acc_out=0, acc_ovf=0, drop=0, fifo_level=0.
  - Internal sum=0, term count=0, sticky overflow=0, state=ACCUM.
- Priority at each edge: reset > clear > normal operation.
- clear behaves like reset for all state and outputs, but the reset pin stays inactive. A prod_valid arriving in the same cycle as clear is discarded and does not pulse drop.
- Push:
  - When prod_valid is high, prod_in is written to the FIFO if it is not full.
  - A push is also accepted when the FIFO is full and a pop happens in the same cycle.
  - Otherwise the product is discarded and drop is set high for the next cycle only.
- FSM states: ACCUM and OUT.
  - ACCUM, FIFO non-empty: pop the head and compute sum + sext(head) to ACC_W bits.
    - Signed overflow is detected when both operand signs are equal and the result sign differs; any overflow sets the sticky flag.
    - If this is pop number N_TERMS, at the same edge: acc_out = new sum, acc_ovf = sticky | this overflow, acc_valid=1, sum=0, count=0, sticky=0, and the FSM moves to OUT.
    - Otherwise: sum = new sum and count increments.
  - ACCUM, FIFO empty: hold.
  - OUT: no pops; pushes continue. When acc_valid and acc_ready are both high at an edge, acc_valid returns to 0 and the FSM returns to ACCUM. No pop occurs on that same edge.
- Arithmetic wraps modulo 2^ACC_W; acc_ovf is the only indication of overflow.
- acc_out and acc_ovf are held stable while acc_valid is high.
- There is no bypass: a product pushed at edge t is popped at edge t+1 at the earliest.

## Timing
- Product-to-sum latency: 1 cycle from the push edge to the pop/accumulate edge.
- Final product: pushed at edge t gives acc_valid high after edge t+1 (FIFO otherwise empty, FSM in ACCUM).
- Throughput: one pop per cycle in ACCUM.
- Each result costs at least one OUT cycle, so back-to-back results need at least N_TERMS+1 cycles each.
- fifo_level reflects pushes and pops committed at the previous edge.
- drop is a registered pulse, high exactly one cycle per rejected product.

## Test plan
1. Reset: hold rst_n low for 2 edges with prod_valid=1 -> all outputs 0, fifo_level=0, no drop pulse.
2. Basic sum (defaults, acc_ready=1): products 6, -10 (16'hFFF6), 16384 (16'h4000), -16384 (16'hC000), spaced 10 cycles apart -> acc_out=20'hFFFFC (-4), acc_ovf=0, acc_valid high one cycle after the 4th push edge.
3. Overflow (ACC_W=17): four products of 16384 -> acc_out=17'h10000, acc_ovf=1. A following result of 1,1,1,1 -> acc_out=4, acc_ovf=0 (sticky flag cleared).
4. Back-pressure and drop:
   - Hold acc_ready=0 after the first result is valid, then push 5 products.
   - Required: fifo_level rises to 4, the 5th push pulses drop for 1 cycle, fifo_level stays 4.
   - Then set acc_ready=1: the first result is consumed, and the next result is the sum of the 4 buffered products.
5. Clear mid-sum: push 100 and 200, then pulse clear together with a prod_valid of 999. Then push 1, 2, 3, 4 -> acc_out=10, no drop pulse, fifo_level=0 immediately after clear.
6. Streaming: prod_valid high for 8 consecutive cycles with values 1..8 and acc_ready=1 -> two results, 10 then 26, no drop pulses, fifo_level ends at 0.
